// File: rtl/kbd_event_fifo.sv
// Folds PS/2 set-2 scan-code bytes into key events {release, ext, code}
// and queues them in a fall-through FIFO popped by the CPU.
module kbd_event_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            ps2_data,
    input  logic                  ps2_hit,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [9:0]            q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned EW    = 10;
    localparam int unsigned SW    = 3;

    typedef enum logic {ST_IDLE, ST_SKIP} state_t;

    state_t          state;
    logic            ext;
    logic            rel;
    logic [SW-1:0]   skip_cnt;

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            push_c;
    logic [EW-1:0]   push_ev_c;
    logic            do_push_c;
    logic            do_pop_c;
    logic            drop_c;
    logic [CW-1:0]   count_nxt_c;

    // Event decode for the byte strobed this cycle
    always_comb begin
        push_c    = 1'b0;
        push_ev_c = {rel, ext, ps2_data};
        if (ps2_hit && state == ST_IDLE) begin
            case (ps2_data)
                8'hE0, 8'hF0: push_c = 1'b0;
                8'hE1: begin
                    push_c    = 1'b1;
                    push_ev_c = {1'b0, 1'b1, 8'hE1};
                end
                // Keyboard replies only count as keys when a prefix preceded them
                8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: push_c = ext | rel;
                default: push_c = 1'b1;
            endcase
        end
    end

    // Assembler FSM: prefix flags and Pause-sequence skipping
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ext      <= 1'b0;
            rel      <= 1'b0;
            skip_cnt <= '0;
        end else if (ps2_hit) begin
            case (state)
                ST_IDLE: begin
                    case (ps2_data)
                        8'hE0: ext <= 1'b1;
                        8'hF0: rel <= 1'b1;
                        8'hE1: begin
                            state    <= ST_SKIP;
                            skip_cnt <= SW'(7);
                            ext      <= 1'b0;
                            rel      <= 1'b0;
                        end
                        default: begin
                            ext <= 1'b0;
                            rel <= 1'b0;
                        end
                    endcase
                end
                ST_SKIP: begin
                    skip_cnt <= skip_cnt - SW'(1);
                    if (skip_cnt == SW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign do_pop_c  = rd & ~empty;
    assign do_push_c = push_c & (~full | do_pop_c);
    assign drop_c    = push_c & full & ~do_pop_c;

    always_comb begin
        count_nxt_c = count;
        if (do_push_c && !do_pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    // Pointers and registered status
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == CW'(DEPTH));
            if (drop_c) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage is not reset; contents behind the pointers are simply abandoned
    always_ff @(posedge clock) begin
        if (reset_n && do_push_c) begin
            mem[wr_ptr] <= push_ev_c;
        end
    end

    assign q = mem[rd_ptr];

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo: directed scenarios plus random byte streams
// compared each cycle with a queue-based model of the key-event rules.
module tb_kbd_event_fifo;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_hit = 1'b0;
    logic       rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [9:0] q;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;

    int total = 0;
    int bad = 0;

    logic [9:0] mq[$];
    bit         m_ext, m_rel, m_ovf;
    int         m_skip;

    kbd_event_fifo #(.DEPTH_LOG2(4)) dut (
        .clock(clock), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_hit(ps2_hit),
        .rd(rd), .clr_ovf(clr_ovf), .q(q), .empty(empty), .full(full),
        .count(count), .ovf(ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_noise(input logic [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    // Apply one clock edge of the key-event rules to the model
    task automatic model_edge();
        bit         pop;
        bit         push;
        bit         dropped;
        logic [9:0] ev;
        if (!reset_n) begin
            mq.delete();
            m_ext = 0; m_rel = 0; m_ovf = 0; m_skip = 0;
            return;
        end
        pop = rd && mq.size() > 0;
        push = 0;
        dropped = 0;
        ev = '0;
        if (ps2_hit) begin
            if (m_skip > 0) begin
                m_skip--;
            end else if (ps2_data == 8'hE0) begin
                m_ext = 1;
            end else if (ps2_data == 8'hF0) begin
                m_rel = 1;
            end else if (ps2_data == 8'hE1) begin
                push = 1; ev = 10'h1E1; m_skip = 7; m_ext = 0; m_rel = 0;
            end else if (is_noise(ps2_data) && !m_ext && !m_rel) begin
                push = 0;
            end else begin
                push = 1; ev = {m_rel, m_ext, ps2_data}; m_ext = 0; m_rel = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < 16) mq.push_back(ev);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (mq.size() > 0) chk("q", 32'(q), 32'(mq[0]));
    endtask

    task automatic tick(input logic hit, input logic [7:0] d, input logic r, input logic c);
        @(negedge clock);
        ps2_hit = hit; ps2_data = d; rd = r; clr_ovf = c;
        @(posedge clock);
        model_edge();
        #1;
        ps2_hit = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        model_edge();
        #1;
        reset_n = 1'b1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] pick [10] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h29};

    initial begin
        // Reset and basic press
        do_reset();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        send(8'h1C);
        chk("press_q", 32'(q), 32'h01C);
        chk("press_count", 32'(count), 32'd1);
        pop();
        chk("press_pop_empty", 32'(empty), 32'd1);

        // Prefixed releases in both prefix orders
        send(8'hE0); send(8'hF0);
        chk("prefix_no_push", 32'(count), 32'd0);
        send(8'h75);
        send(8'hF0); send(8'hE0); send(8'h6B);
        chk("rel_count", 32'(count), 32'd2);
        chk("rel_q0", 32'(q), 32'h375);
        pop();
        chk("rel_q1", 32'(q), 32'h36B);
        pop();

        // Pause sequence then keyboard replies
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        send(8'hAA); send(8'hFA); send(8'h29);
        chk("pause_count", 32'(count), 32'd2);
        chk("pause_q0", 32'(q), 32'h1E1);
        pop();
        chk("pause_q1", 32'(q), 32'h029);
        pop();

        // Overflow
        for (int i = 8'h10; i <= 8'h20; i++) send(8'(i));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_order", 32'(q), 32'h010 + 32'(i));
            pop();
        end
        chk("ovf_drained", 32'(empty), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Push and pop together while full
        for (int i = 8'h40; i < 8'h50; i++) send(8'(i));
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        chk("pp_full_count", 32'(count), 32'd16);
        chk("pp_full_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 15; i++) pop();
        chk("pp_full_tail", 32'(q), 32'h055);
        pop();

        // Push and pop together while empty
        tick(1'b1, 8'h33, 1'b1, 1'b0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_q", 32'(q), 32'h033);
        pop();

        // Reset after a release prefix
        send(8'hF0);
        do_reset();
        send(8'h1C);
        chk("rst_prefix_q", 32'(q), 32'h01C);
        chk("rst_prefix_count", 32'(count), 32'd1);

        // Random streams
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                b = ($urandom_range(0, 2) == 0) ? 8'($urandom) : pick[$urandom_range(0, 9)];
                tick(1'($urandom_range(0, 99) < 60), b,
                     1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 5));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_event_fifo.md
# kbd_event_fifo

Scan-code assembler and event buffer between the PS/2 receiver (`ps2keyboard`) and the memory controller's keyboard port. It takes raw set-2 bytes with their one-cycle strobe. It folds `E0`/`F0` prefixes and the `E1` Pause sequence into single key events and queues them in a FIFO. The CPU pops events at its own pace instead of racing the receiver's single-byte register.

## Interface

Parameters:
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).

Ports:
- `clock`  in  1  single clock. Receiver strobe and CPU pop strobe are both synchronous to it.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising `clock`.
- `ps2_data`  in  8  received byte, valid while `ps2_hit`=1.
- `ps2_hit`  in  1  one-cycle strobe, one per received byte.
- `rd`  in  1  pop strobe. One pop per cycle where `rd`=1 and `empty`=0.
- `clr_ovf`  in  1  clears `ovf`.
- `q`  out  10  head event `{release, ext, code[7:0]}`, fall-through. Undefined-but-stable when empty.
- `empty`  out  1  FIFO holds no events.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 events.
- `count`  out  DEPTH_LOG2+1  number of stored events.
- `ovf`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation

Assembler FSM, advanced only on cycles with `ps2_hit`=1:
- **IDLE**
  - `E0` → set `ext`, stay IDLE.
  - `F0` → set `rel`, stay IDLE.
  - `E1` → push event `{0,1,8'hE1}`, load skip counter with 7, go SKIP.
  - `FA`/`AA`/`EE`/`FE`/`00`/`FF` with neither flag set → discard, no push.
  - Any other byte → push `{rel, ext, byte}`, clear both flags.
  - Flags accumulate in either order: `E0 F0 xx` and `F0 E0 xx` both give release+ext.
- **SKIP**
  - Each byte decrements the counter, with no push.
  - The byte that brings the counter to 0 returns the FSM to IDLE with flags clear.

FIFO:
- Circular buffer of 2^DEPTH_LOG2 × 10 bits.
- Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- `count` tracks occupancy.

Boundary rules:
- **Push while full, no pop:** event dropped, `ovf`←1, pointers and count unchanged.
- **Push and pop in the same cycle, not empty:** both performed, `count` unchanged. This holds when full, so no overflow occurs.
- **Push and pop in the same cycle, empty:** pop ignored, push performed, `count`=1.
- **Pop while empty:** ignored. No pointer change, no underflow.
- **`ovf` set and `clr_ovf` in the same cycle:** set wins, `ovf`=1.

Reset (`reset_n`=0 at an edge) clears:
- pointers; `count`=0, `empty`=1, `full`=0, `ovf`=0
- FSM→IDLE, `ext`=`rel`=0, skip counter=0

Reset mid-sequence (e.g. after `F0`) discards the pending prefix. FIFO contents are not cleared, only abandoned.

## Timing

- Event push is registered on the edge where `ps2_hit`=1 with the final byte. `empty`/`count`/`full` reflect it on the following cycle. Latency is 1 clock from strobe to visibility.
- `q` is combinational from the read pointer and storage. The new head is visible the cycle after a pop edge.
- Back-to-back `ps2_hit` on consecutive cycles is fully supported.
- Storage may be LUT or MLAB. It must be readable asynchronously for fall-through.
- Status outputs are registered. There is no combinational path from `rd` or `ps2_hit` to any output.

## Test plan

- **Reset and basic press.** After reset: `empty`=1, `count`=0, `ovf`=0. Send `1C` → next cycle `q`=`0_0_1C`, `empty`=0, `count`=1. Pulse `rd` → `empty`=1.
- **Prefixed release.** Send `E0 F0 75`, then `F0 E0 6B` → two events `1_1_75` and `1_1_6B`, no intermediate pushes.
- **Pause sequence and noise.** Send `E1 14 77 E1 F0 14 F0 77`, then `AA FA 29` → exactly two events `0_1_E1`, `0_0_29`.
- **Overflow.** Push 17 distinct codes `10`..`20`, no reads → `full`=1, `count`=16, `ovf`=1. Pops return `10`..`1F` in order, then `empty`. `clr_ovf` clears `ovf`.
- **Simultaneous push and pop.**
  - When full: `rd` together with final byte `55` → `count` stays 16, `ovf` stays 0, tail is `55`.
  - When empty: `rd` together with `33` → `count`=1, `q`=`0_0_33`.
- **Reset mid-prefix.** Send `F0`, assert `reset_n`=0 for one edge, then send `1C` → event `0_0_1C` (release flag gone).
